// File: rtl/mod_cfg_pkg.sv
// Shared types for the modulus config loader feeding the dual 10-bit counter pair.
package mod_cfg_pkg;

    localparam int MOD_W = 10;

    typedef logic [MOD_W-1:0] mod_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_e;

    typedef enum logic {
        S_IDLE,
        S_PEND
    } cfg_state_e;

endpackage

// File: rtl/mod_cfg_chan.sv
// One channel: shadow register, active modulus, apply-on-wrap FSM and timeout counter.
module mod_cfg_chan
    import mod_cfg_pkg::*;
#(
    parameter mod_t RST_MOD = 10'd10,
    parameter int   TIMEOUT = 1024,
    parameter int   TO_W    = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic wr,
    input  mod_t data,
    input  logic cout,
    output mod_t active,
    output logic pend,
    output logic apply,
    output logic forced
);

    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

    cfg_state_e      state, nxt;
    mod_t            shadow;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            load, do_apply, do_force;

    assign to_hit = TO_EN && (to_cnt == TO_LAST);
    assign pend   = (state == S_PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (wr) nxt = S_PEND;
            S_PEND:  if (cout || to_hit) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // A wrap in the same cycle as the timeout wins, so forced stays low.
    always_comb begin
        load     = 1'b0;
        do_apply = 1'b0;
        do_force = 1'b0;
        case (state)
            S_IDLE: load = wr;
            S_PEND: begin
                do_apply = cout || to_hit;
                do_force = to_hit && !cout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= RST_MOD;
            shadow <= '0;
            to_cnt <= '0;
            apply  <= 1'b0;
            forced <= 1'b0;
        end else begin
            apply  <= do_apply;
            forced <= do_force;
            if (load) begin
                shadow <= data;
                to_cnt <= '0;
            end else if (state == S_PEND && to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (do_apply) active <= shadow;
        end
    end

endmodule

// File: rtl/mod_cfg_loader.sv
// Config loader: valid/ready write port decoded onto two shadowed modulus channels.
module mod_cfg_loader
    import mod_cfg_pkg::*;
#(
    parameter mod_t RST_MOD = 10'd10,
    parameter int   MIN_MOD = 2,
    parameter int   TIMEOUT = 1024,
    parameter int   TO_W    = 11
) (
    input  logic CLK,
    input  logic rst,
    input  logic cfg_valid,
    input  logic cfg_sel,
    input  mod_t cfg_data,
    output logic cfg_ready,
    output logic cfg_err,
    input  logic CoutA,
    input  logic CoutB,
    output mod_t cntA_Module,
    output mod_t cntB_Module,
    output logic pendA,
    output logic pendB,
    output logic applyA,
    output logic applyB,
    output logic forcedA,
    output logic forcedB
);

    logic xfer, legal, wr_a, wr_b;

    // Ready only looks at the selected channel's pend, never at cfg_valid.
    assign cfg_ready = (chan_e'(cfg_sel) == CH_B) ? !pendB : !pendA;
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = (cfg_data >= MOD_W'(MIN_MOD));
    assign wr_a      = xfer && legal && (chan_e'(cfg_sel) == CH_A);
    assign wr_b      = xfer && legal && (chan_e'(cfg_sel) == CH_B);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) cfg_err <= 1'b0;
        else     cfg_err <= xfer && !legal;
    end

    mod_cfg_chan #(.RST_MOD(RST_MOD), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_chan_a (
        .clk    (CLK),
        .rst    (rst),
        .wr     (wr_a),
        .data   (cfg_data),
        .cout   (CoutA),
        .active (cntA_Module),
        .pend   (pendA),
        .apply  (applyA),
        .forced (forcedA)
    );

    mod_cfg_chan #(.RST_MOD(RST_MOD), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_chan_b (
        .clk    (CLK),
        .rst    (rst),
        .wr     (wr_b),
        .data   (cfg_data),
        .cout   (CoutB),
        .active (cntB_Module),
        .pend   (pendB),
        .apply  (applyB),
        .forced (forcedB)
    );

endmodule

// File: tb/tb_mod_cfg_loader.sv
// Directed bench: default-timeout instance for the main flow, TIMEOUT=8 instance for forced applies.
module tb_mod_cfg_loader;
    import mod_cfg_pkg::*;

    logic CLK = 1'b0;
    logic rst;
    logic cfg_valid, cfg_sel, CoutA, CoutB;
    mod_t cfg_data;

    logic cfg_ready, cfg_err, pendA, pendB, applyA, applyB, forcedA, forcedB;
    mod_t cntA_Module, cntB_Module;

    logic t_ready, t_err, t_pendA, t_pendB, t_applyA, t_applyB, t_forcedA, t_forcedB;
    mod_t t_modA, t_modB;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mod_cfg_loader dut (
        .CLK(CLK), .rst(rst), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .CoutA(CoutA), .CoutB(CoutB),
        .cntA_Module(cntA_Module), .cntB_Module(cntB_Module), .pendA(pendA), .pendB(pendB),
        .applyA(applyA), .applyB(applyB), .forcedA(forcedA), .forcedB(forcedB)
    );

    mod_cfg_loader #(.TIMEOUT(8), .TO_W(4)) dut_to (
        .CLK(CLK), .rst(rst), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_ready(t_ready), .cfg_err(t_err), .CoutA(CoutA), .CoutB(CoutB),
        .cntA_Module(t_modA), .cntB_Module(t_modB), .pendA(t_pendA), .pendB(t_pendB),
        .applyA(t_applyA), .applyB(t_applyB), .forcedA(t_forcedA), .forcedB(t_forcedB)
    );

    typedef struct {
        logic valid;
        logic sel;
        int   data;
        logic ca;
        logic cb;
        int   modA;
        int   modB;
        logic pA;
        logic pB;
        logic aA;
        logic aB;
        logic err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic s, input int d, input logic ca, input logic cb);
        cfg_valid = v;
        cfg_sel   = s;
        cfg_data  = mod_t'(d);
        CoutA     = ca;
        CoutB     = cb;
    endtask

    initial begin
        // state entering the table: A=600, B=300, both idle
        vecs[0] = '{1'b1, 1'b1, 1,    1'b0, 1'b0, 600,  300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 0,    1'b0, 1'b0, 600,  300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 0,    1'b0, 1'b0, 600,  300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 2,    1'b0, 1'b0, 600,  300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 0,    1'b0, 1'b1, 600,  300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 0,    1'b1, 1'b0, 2,    300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 300,  1'b0, 1'b0, 2,    300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 0,    1'b0, 1'b1, 2,    300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1023, 1'b0, 1'b0, 2,    300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 0,    1'b1, 1'b0, 1023, 300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("rst_modA", int'(cntA_Module), 10);
        chk("rst_modB", int'(cntB_Module), 10);
        chk("rst_pendA", int'(pendA), 0);
        chk("rst_pendB", int'(pendB), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_err", int'(cfg_err), 0);
        rst = 1'b0;
        cyc();

        // write A=500, wrap 20 cycles later
        drive(1'b1, 1'b0, 500, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("w500_pendA", int'(pendA), 1);
        chk("w500_ready", int'(cfg_ready), 0);
        for (int i = 0; i < 19; i++) begin
            cyc();
            chk("w500_hold_pendA", int'(pendA), 1);
            chk("w500_hold_modA", int'(cntA_Module), 10);
        end
        CoutA = 1'b1;
        cyc();
        CoutA = 1'b0;
        chk("w500_applyA", int'(applyA), 1);
        chk("w500_modA", int'(cntA_Module), 500);
        chk("w500_pendA_clr", int'(pendA), 0);
        chk("w500_modB", int'(cntB_Module), 10);
        chk("w500_forcedA", int'(forcedA), 0);
        cyc();
        chk("w500_apply_pulse", int'(applyA), 0);

        // blocked second write to A, simultaneous accept on B
        drive(1'b1, 1'b0, 600, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 700, 1'b0, 1'b0);
        #1 chk("blk_readyA", int'(cfg_ready), 0);
        drive(1'b1, 1'b1, 300, 1'b0, 1'b0);
        #1 chk("blk_readyB", int'(cfg_ready), 1);
        cyc();
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("blk_pendA", int'(pendA), 1);
        chk("blk_pendB", int'(pendB), 1);
        cyc();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("both_applyA", int'(applyA), 1);
        chk("both_applyB", int'(applyB), 1);
        chk("both_modA", int'(cntA_Module), 600);
        chk("both_modB", int'(cntB_Module), 300);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ca, vecs[i].cb);
            cyc();
            chk($sformatf("v%0d_modA", i), int'(cntA_Module), vecs[i].modA);
            chk($sformatf("v%0d_modB", i), int'(cntB_Module), vecs[i].modB);
            chk($sformatf("v%0d_pendA", i), int'(pendA), int'(vecs[i].pA));
            chk($sformatf("v%0d_pendB", i), int'(pendB), int'(vecs[i].pB));
            chk($sformatf("v%0d_applyA", i), int'(applyA), int'(vecs[i].aA));
            chk($sformatf("v%0d_applyB", i), int'(applyB), int'(vecs[i].aB));
            chk($sformatf("v%0d_err", i), int'(cfg_err), int'(vecs[i].err));
        end
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // timeout: fresh reset, write A=33, never wrap
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b1, 1'b0, 33, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("to_wait_pendA", int'(t_pendA), 1);
            chk("to_wait_applyA", int'(t_applyA), 0);
        end
        cyc();
        chk("to_applyA", int'(t_applyA), 1);
        chk("to_forcedA", int'(t_forcedA), 1);
        chk("to_modA", int'(t_modA), 33);
        chk("to_pendA", int'(t_pendA), 0);
        chk("to_main_pendA", int'(pendA), 1);
        chk("to_main_modA", int'(cntA_Module), 10);
        cyc();
        chk("to_forced_pulse", int'(t_forcedA), 0);

        // timeout and wrap on the same edge: one apply, not forced
        drive(1'b1, 1'b0, 44, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc();
        chk("tie_pendA", int'(t_pendA), 1);
        CoutA = 1'b1;
        cyc();
        CoutA = 1'b0;
        chk("tie_applyA", int'(t_applyA), 1);
        chk("tie_forcedA", int'(t_forcedA), 0);
        chk("tie_modA", int'(t_modA), 44);
        chk("tie_main_modA", int'(cntA_Module), 33);
        cyc();

        // wrap coincident with the accepting write is not used
        drive(1'b1, 1'b0, 7, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("co_pendA", int'(pendA), 1);
        chk("co_applyA", int'(applyA), 0);
        chk("co_modA", int'(cntA_Module), 33);
        cyc();
        cyc();
        chk("co_hold_pendA", int'(pendA), 1);
        CoutA = 1'b1;
        cyc();
        CoutA = 1'b0;
        chk("co_applyA2", int'(applyA), 1);
        chk("co_modA2", int'(cntA_Module), 7);

        // async reset mid-cycle discards a pending B write
        drive(1'b1, 1'b1, 77, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 0, 1'b0, 1'b0);
        chk("ar_pendB", int'(pendB), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_modB", int'(cntB_Module), 10);
        chk("ar_modA", int'(cntA_Module), 10);
        chk("ar_pendB_clr", int'(pendB), 0);
        chk("ar_ready", int'(cfg_ready), 1);
        #1 rst = 1'b0;
        CoutB = 1'b1;
        cyc();
        CoutB = 1'b0;
        chk("ar_post_modB", int'(cntB_Module), 10);
        chk("ar_post_applyB", int'(applyB), 0);
        chk("ar_post_pendB", int'(pendB), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
